// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Owns the PC, runs the instruction
// memory request/ack handshake, and presents PC+4 and the fetched instruction
// to the IF/ID pipeline register. It tolerates any memory latency, absorbs
// one instruction of ID-stage stall back-pressure in a single-entry hold
// buffer, and handles branch/jump redirects, including redirects that arrive
// while a fetch is still outstanding.
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset
//   stall       IF/ID hold; output registers keep their value while 1
//   redirect    branch/jump taken (single-cycle pulse)
//   redirect_pc redirect target, sampled when redirect=1
//   imem_req    fetch request, held until imem_ack
//   imem_addr   fetch address, stable while imem_req=1
//   imem_ack    response valid this cycle (ignored unless imem_req=1)
//   imem_rdata  instruction returned with imem_ack
//   pc_out      PC+4 of the presented instruction
//   instr_out   presented instruction, 0 when bubble
//   if_valid    presented instruction is real
//   trap        one-cycle pulse after a misaligned redirect
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   - a redirect to a non-word-aligned target jumps to EXC_VECTOR
//               and pulses trap in the following cycle
//   undefined - redirect_pc is used as-is and trap stays 0

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        if_valid,
  output logic        trap
);

  // RUN: fetching at pc. DISCARD: waiting out a stale fetch at old_pc.
  // FULL: hold buffer occupied, no request issued.
  typedef enum logic [1:0] {
    S_RUN,
    S_DISCARD,
    S_FULL
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;

  logic        ack_seen;
  logic        accepted;
  logic        misaligned;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;

`ifdef IF_MISALIGN_TRAP_EN
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The request is gated by rst so it is low during the reset cycle itself.
  assign imem_req        = !rst && (state != S_FULL);
  assign imem_addr       = (state == S_DISCARD) ? old_pc : pc;
  assign ack_seen        = imem_ack && imem_req;
  assign accepted        = ack_seen && (state == S_RUN);
  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = misaligned ? EXC_VECTOR : redirect_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      old_pc    <= 32'h0;
      buf_pc    <= 32'h0;
      buf_instr <= 32'h0;
      pc_out    <= 32'h0;
      instr_out <= 32'h0;
      if_valid  <= 1'b0;
      trap      <= 1'b0;
    end else begin
      trap <= redirect && misaligned;
      if (redirect) begin
        // Redirect flushes ID, so outputs go to bubble even under stall.
        pc        <= redirect_target;
        pc_out    <= 32'h0;
        instr_out <= 32'h0;
        if_valid  <= 1'b0;
        case (state)
          S_RUN: begin
            // An in-flight fetch with no ack yet must be drained and dropped.
            if (!ack_seen) begin
              state  <= S_DISCARD;
              old_pc <= pc;
            end
          end
          S_DISCARD: begin
            // Still only one stale response outstanding; old_pc is kept.
            if (ack_seen) state <= S_RUN;
          end
          default: state <= S_RUN;
        endcase
      end else begin
        if (accepted) pc <= pc_plus4;
        if (state == S_DISCARD && ack_seen) state <= S_RUN;
        if (!stall) begin
          if (state == S_FULL) begin
            pc_out    <= buf_pc + 32'd4;
            instr_out <= buf_instr;
            if_valid  <= 1'b1;
            state     <= S_RUN;
          end else if (accepted) begin
            pc_out    <= pc_plus4;
            instr_out <= imem_rdata;
            if_valid  <= 1'b1;
          end else begin
            pc_out    <= 32'h0;
            instr_out <= 32'h0;
            if_valid  <= 1'b0;
          end
        end else if (accepted) begin
          // Outputs are frozen; park the fetched instruction until release.
          buf_instr <= imem_rdata;
          buf_pc    <= pc;
          state     <= S_FULL;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit.
// Inputs change on the falling edge; all outputs are sampled 1 time unit
// later, well away from the rising edge. Memory data is a fixed function of
// the fetch address so expected instructions are known constants.

module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        if_valid;
  logic        trap;

  int n_compared;
  int n_mismatched;

  logic [31:0] exp_mis_addr;
  logic [31:0] exp_mis_trap;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .if_valid    (if_valid),
    .trap        (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hE000_0000 ^ a;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [31:0] rpc, input logic a);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = a;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
`ifdef IF_MISALIGN_TRAP_EN
    exp_mis_addr = 32'h0000_0180;
    exp_mis_trap = 32'd1;
`else
    exp_mis_addr = 32'h0000_0102;
    exp_mis_trap = 32'd0;
`endif
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("rst_req", {31'h0, imem_req}, 32'd0);
    checkOutput("rst_pc_out", pc_out, 32'h0);
    checkOutput("rst_instr", instr_out, 32'h0);
    checkOutput("rst_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("rst_trap", {31'h0, trap}, 32'd0);
    @(negedge clk);

    // Zero-latency acks, one instruction per cycle
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("first_req", {31'h0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("seq_addr4", imem_addr, 32'h4);
    checkOutput("seq_pc4", pc_out, 32'h4);
    checkOutput("seq_instr0", instr_out, instr_of(32'h0));
    checkOutput("seq_valid0", {31'h0, if_valid}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("seq_addr8", imem_addr, 32'h8);
    checkOutput("seq_pc8", pc_out, 32'h8);
    checkOutput("seq_instr4", instr_out, instr_of(32'h4));
    @(negedge clk);

    // Three-cycle ack latency at 0xC
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("lat_addr_c0", imem_addr, 32'hC);
    checkOutput("seq_pc12", pc_out, 32'hC);
    checkOutput("seq_instr8", instr_out, instr_of(32'h8));
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("lat_addr_c1", imem_addr, 32'hC);
    checkOutput("lat_bubble_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("lat_bubble_instr", instr_out, 32'h0);
    checkOutput("lat_bubble_pc", pc_out, 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("lat_addr_c2", imem_addr, 32'hC);
    checkOutput("lat_req_c2", {31'h0, imem_req}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("lat_addr_c3", imem_addr, 32'hC);
    @(negedge clk);

    // Stall for 4 cycles while the ack for 0x10 arrives
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("lat_pc16", pc_out, 32'h10);
    checkOutput("lat_instr12", instr_out, instr_of(32'hC));
    checkOutput("stall_addr16", imem_addr, 32'h10);
    @(negedge clk);
    applyStimulus(0, 1, 0, 32'h0, 1);
    checkOutput("stall_hold_pc", pc_out, 32'h10);
    checkOutput("stall_req_before_ack", {31'h0, imem_req}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("full_req_drop", {31'h0, imem_req}, 32'd0);
    checkOutput("full_hold_pc", pc_out, 32'h10);
    checkOutput("full_hold_instr", instr_out, instr_of(32'hC));
    @(negedge clk);
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("full_req_drop2", {31'h0, imem_req}, 32'd0);
    checkOutput("full_hold_valid", {31'h0, if_valid}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("release_req", {31'h0, imem_req}, 32'd0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("buf_pc", pc_out, 32'h14);
    checkOutput("buf_instr", instr_out, instr_of(32'h10));
    checkOutput("buf_valid", {31'h0, if_valid}, 32'd1);
    checkOutput("after_buf_addr", imem_addr, 32'h14);
    @(negedge clk);

    // Redirect and ack in the same cycle under stall
    applyStimulus(0, 1, 1, 32'h40, 1);
    checkOutput("pre_rd_pc", pc_out, 32'h18);
    checkOutput("pre_rd_valid", {31'h0, if_valid}, 32'd1);
    checkOutput("pre_rd_addr", imem_addr, 32'h18);
    @(negedge clk);
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("rdack_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("rdack_pc", pc_out, 32'h0);
    checkOutput("rdack_instr", instr_out, 32'h0);
    checkOutput("rdack_addr", imem_addr, 32'h40);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("rdack_addr_hold", imem_addr, 32'h40);
    @(negedge clk);

    // Redirect to 0x200 with the 0x40 fetch outstanding, ack two cycles later
    applyStimulus(0, 0, 1, 32'h200, 0);
    checkOutput("rdack_buf_empty", {31'h0, if_valid}, 32'd0);
    checkOutput("disc_pre_addr", imem_addr, 32'h40);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("disc_req", {31'h0, imem_req}, 32'd1);
    checkOutput("disc_old_addr", imem_addr, 32'h40);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("disc_old_addr2", imem_addr, 32'h40);
    checkOutput("disc_valid", {31'h0, if_valid}, 32'd0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("disc_dropped_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("disc_dropped_instr", instr_out, 32'h0);
    checkOutput("disc_new_addr", imem_addr, 32'h200);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("disc_pc204", pc_out, 32'h204);
    checkOutput("disc_instr200", instr_out, instr_of(32'h200));
    checkOutput("disc_valid204", {31'h0, if_valid}, 32'd1);
    checkOutput("disc_next_addr", imem_addr, 32'h204);
    @(negedge clk);

    // Two redirects back to back: only one stale response dropped
    applyStimulus(0, 0, 1, 32'h300, 0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 32'h400, 0);
    checkOutput("dd_addr1", imem_addr, 32'h204);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("dd_addr2", imem_addr, 32'h204);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("dd_new_addr", imem_addr, 32'h400);
    checkOutput("dd_valid", {31'h0, if_valid}, 32'd0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 32'h0, 1);
    checkOutput("dd_pc404", pc_out, 32'h404);
    checkOutput("dd_valid404", {31'h0, if_valid}, 32'd1);
    checkOutput("dd_addr404", imem_addr, 32'h404);
    @(negedge clk);

    // Redirect while FULL
    applyStimulus(0, 1, 1, 32'h500, 0);
    checkOutput("rdfull_req", {31'h0, imem_req}, 32'd0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("rdfull_addr", imem_addr, 32'h500);
    checkOutput("rdfull_req_on", {31'h0, imem_req}, 32'd1);
    checkOutput("rdfull_valid", {31'h0, if_valid}, 32'd0);
    @(negedge clk);

    // Misaligned redirect, dropped same-cycle ack
    applyStimulus(0, 0, 1, 32'h102, 1);
    checkOutput("mis_pre_trap", {31'h0, trap}, 32'd0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 1);
    checkOutput("mis_trap", {31'h0, trap}, exp_mis_trap);
    checkOutput("mis_addr", imem_addr, exp_mis_addr);
    @(negedge clk);

    // PC+4 wrap at the top of the address space
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("mis_trap_clear", {31'h0, trap}, 32'd0);
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("wrap_pc_out", pc_out, 32'h0);
    checkOutput("wrap_instr", instr_out, instr_of(32'hFFFF_FFFC));
    checkOutput("wrap_valid", {31'h0, if_valid}, 32'd1);
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    @(negedge clk);

    // Reset in mid-run
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("rst2_req", {31'h0, imem_req}, 32'd0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("rst2_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("rst2_addr", imem_addr, 32'h0);
    checkOutput("rst2_req_on", {31'h0, imem_req}, 32'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the multicycle/pipelined CPU: owns the PC, drives the instruction-memory handshake, and produces PC+4 and instruction for the IF/ID pipeline register.
- Handles multicycle memory latency, ID-stage stall back-pressure (one-entry hold buffer) and branch/jump redirects, including redirects that arrive while a fetch is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h0000_0180, target used by the misaligned-redirect trap (optional feature only)

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- stall  input  1  IF/ID hold; while 1, output registers must not change
- redirect  input  1  branch/jump taken; single-cycle pulse
- redirect_pc  input  32  redirect target, sampled when redirect=1
- imem_req  output  1  fetch request, level; held until imem_ack
- imem_addr  output  32  fetch address, stable while imem_req=1
- imem_ack  input  1  response valid this cycle; ignored unless imem_req=1
- imem_rdata  input  32  instruction, valid with imem_ack
- pc_out  output  32  PC+4 of the presented instruction; feeds IF/ID PCin
- instr_out  output  32  presented instruction, 0 (NOP) when bubble
- if_valid  output  1  presented instruction is real
- trap  output  1  one-cycle pulse, misaligned redirect (optional feature)

Behaviour:
- Reset (rst=1 at posedge, overrides everything):
  - pc=RESET_PC, state=RUN, hold buffer empty, discard flag clear.
  - pc_out=0, instr_out=0, if_valid=0, trap=0. imem_req=0 in the reset cycle.
  - imem_req=1 with imem_addr=RESET_PC in the first cycle after rst drops.
- States:
  - RUN: imem_req=1, imem_addr=pc.
  - DISCARD: imem_req=1, imem_addr=old pc; the pending response is dropped.
  - FULL: imem_req=0; hold buffer occupied.
- Handshake:
  - imem_ack may arrive in the same cycle as imem_req (minimum latency 0) or any later cycle.
  - Ack in RUN accepts the fetch and sets pc=pc+4.
  - Next request issues in the cycle after the ack, giving a peak rate of one instruction per cycle.
- Output update, posedge with stall=0 and no redirect, priority order:
  - (1) Buffer full: present buffer (pc_out=buf_pc+4, instr_out=buf_instr, if_valid=1), empty the buffer, FULL->RUN.
  - (2) Else accepted ack: present imem_rdata with pc_out=fetch_addr+4, if_valid=1.
  - (3) Else bubble: pc_out=0, instr_out=0, if_valid=0.
- stall=1:
  - Outputs hold their values.
  - An accepted ack is written into the hold buffer and the state goes RUN->FULL.
  - No new request is issued while in FULL.
  - Buffer depth is 1; the FULL state guarantees no overflow.
- Redirect (priority over stall and buffer):
  - pc=redirect_pc, buffer emptied, outputs forced to bubble even if stall=1, because the ID stage is being flushed.
  - Fetch outstanding with no ack this cycle: state goes to DISCARD. imem_req stays high at the old address until ack, then that data is dropped and the state returns to RUN at redirect_pc.
  - Ack in the same cycle as the redirect: data dropped, state goes to RUN, next request at redirect_pc.
  - Redirect while in DISCARD: the target updates, the state stays DISCARD, and only one response is dropped.
  - Redirect in FULL: state goes to RUN.
- Arithmetic: PC+4 is 32-bit and wraps from 32'hFFFF_FFFC to 0 with no flag.
- The low two bits of pc are always 0 when the optional feature is enabled.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - redirect with redirect_pc[1:0]!=0 loads pc=EXC_VECTOR instead of redirect_pc.
  - trap pulses 1 in the cycle after the redirect.
  - All other redirect rules still apply.
- Undefined:
  - redirect_pc is used unmodified, low bits included.
  - trap is tied to 0.

Test Plan:
- Reset, then ack same cycle every cycle, RESET_PC=0 -> imem_addr 0,4,8,...; pc_out 4,8,12 on consecutive cycles, if_valid=1, instr_out=imem_rdata.
- Ack latency 3 cycles -> imem_addr held stable for 3 cycles; bubbles between fetches (if_valid=0, instr_out=0).
- stall=1 for 4 cycles while the ack for addr 0x10 arrives -> outputs frozen, imem_req drops after the ack. On stall release, pc_out=0x14 with the buffered instruction; the next request is to 0x14.
- Redirect to 0x200 with the fetch at 0x40 outstanding, ack 2 cycles later -> 0x40 data never reaches if_valid=1; the next imem_addr is 0x200 and the next valid pc_out is 0x204.
- Redirect and ack in the same cycle, with stall=1 -> outputs go to bubble, the buffer stays empty, and the next request is to redirect_pc.
- With IF_MISALIGN_TRAP_EN, redirect_pc=0x102 -> trap=1 for one cycle, next imem_addr=EXC_VECTOR. Without the macro: trap=0 and imem_addr=0x102.
